// File: rtl/uart_cmd_pkg.sv
// Shared encodings for the UART LED command block: channel modes, command
// characters and the parser / transmit state machine states.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2
  } mode_e;

  localparam logic [7:0] CH_BASE  = 8'h41;  // 'A'
  localparam logic [7:0] CH_ACK   = 8'h4B;  // 'K'
  localparam logic [7:0] CH_NAK   = 8'h3F;  // '?'
  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] LF       = 8'h0A;
  localparam logic [7:0] MODE_CH0 = 8'h30;  // '0'

  typedef enum logic {
    P_IDLE   = 1'b0,
    P_GOT_CH = 1'b1
  } parse_state_e;

  typedef enum logic {
    T_IDLE = 1'b0,
    T_WAIT = 1'b1
  } tx_state_e;

endpackage

// File: rtl/uart_led_cmd_sync_fifo.sv
// Small synchronous FIFO with a combinational head. A push into a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_rd_en = i_pop && !o_empty;
  assign w_wr_en = i_push && (!o_full || w_rd_en);
  assign o_dout  = r_mem[r_rd_ptr];

  always_ff @(posedge i_Clock) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_led_cmd.sv
// Two-byte ASCII command parser driving NUM_CH LED channels (off/on/blink),
// with one-byte acknowledgements queued and handed to a UART transmitter.
module uart_led_cmd
  import uart_cmd_pkg::*;
#(
  parameter int          NUM_CH        = 3,
  parameter int          ACC_WIDTH     = 32,
  parameter int unsigned ACC_INC       = 172,
  parameter int          FIFO_DEPTH    = 4,
  parameter int          TIMEOUT_TICKS = 2
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_RX_DV,
  input  logic [7:0]        i_RX_Byte,
  output logic              o_TX_DV,
  output logic [7:0]        o_TX_Byte,
  input  logic              i_TX_Active,
  input  logic              i_TX_Done,
  output logic [NUM_CH-1:0] o_LED,
  output logic              o_Tick,
  output logic              o_Overflow
);

  localparam int         CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int         TO_W    = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [7:0] LAST_CH = 8'(int'(CH_BASE) + NUM_CH - 1);

  // ---------------- phase accumulator ----------------
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_tick;
  logic [ACC_WIDTH:0]   w_acc_sum;
  logic                 w_blink_on;

  assign w_acc_sum  = {1'b0, r_acc} + (ACC_WIDTH+1)'(ACC_INC);
  assign w_blink_on = (r_acc[ACC_WIDTH-1 -: 2] == 2'b00);
  assign o_Tick     = r_tick;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_acc  <= w_acc_sum[ACC_WIDTH-1:0];
      r_tick <= w_acc_sum[ACC_WIDTH];
    end
  end

  // ---------------- command parser ----------------
  parse_state_e    r_pstate;
  parse_state_e    w_pstate_next;
  logic [CH_W-1:0] r_ch;
  logic [TO_W-1:0] r_to_cnt;
  logic [CH_W-1:0] w_ch_off;
  logic [1:0]      w_mode_bits;
  logic            w_is_ch;
  logic            w_is_mode;
  logic            w_is_eol;
  logic            w_timeout;
  logic            w_push;
  logic [7:0]      w_push_byte;
  logic            w_mode_we;
  mode_e           w_mode_val;

  assign w_ch_off    = CH_W'(i_RX_Byte - CH_BASE);
  assign w_mode_bits = 2'(i_RX_Byte - MODE_CH0);
  assign w_is_ch     = (i_RX_Byte >= CH_BASE) && (i_RX_Byte <= LAST_CH);
  assign w_is_mode   = (i_RX_Byte >= MODE_CH0) && (i_RX_Byte <= MODE_CH0 + 8'd2);
  assign w_is_eol    = (i_RX_Byte == CR) || (i_RX_Byte == LF);
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign w_timeout   = (r_pstate == P_GOT_CH) && !i_RX_DV && r_tick &&
                       (r_to_cnt == TO_W'(TIMEOUT_TICKS - 1));

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_pstate <= P_IDLE;
      r_ch     <= '0;
      r_to_cnt <= '0;
    end else begin
      r_pstate <= w_pstate_next;
      if (r_pstate == P_IDLE && i_RX_DV && w_is_ch) begin
        r_ch     <= w_ch_off;
        r_to_cnt <= '0;
      end else if (r_pstate == P_GOT_CH && r_tick) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_pstate_next = r_pstate;
    case (r_pstate)
      P_IDLE:   if (i_RX_DV && w_is_ch) w_pstate_next = P_GOT_CH;
      P_GOT_CH: if (i_RX_DV || w_timeout) w_pstate_next = P_IDLE;
      default:  w_pstate_next = P_IDLE;
    endcase
  end

  always_comb begin
    w_push      = 1'b0;
    w_push_byte = CH_NAK;
    w_mode_we   = 1'b0;
    w_mode_val  = MODE_OFF;
    case (r_pstate)
      P_IDLE: begin
        if (i_RX_DV && !w_is_ch && !w_is_eol) w_push = 1'b1;
      end
      P_GOT_CH: begin
        if (i_RX_DV) begin
          w_push = 1'b1;
          if (w_is_mode) begin
            w_push_byte = CH_ACK;
            w_mode_we   = 1'b1;
            w_mode_val  = mode_e'(w_mode_bits);
          end
        end else if (w_timeout) begin
          w_push = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------- channel modes and LED drive ----------------
  mode_e r_mode [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
        r_mode[gi] <= MODE_OFF;
      end else if (w_mode_we && r_ch == CH_W'(gi)) begin
        r_mode[gi] <= w_mode_val;
      end
    end

    // Active-low drive; the unused encoding falls through to off.
    assign o_LED[gi] = (r_mode[gi] == MODE_ON)    ? 1'b0 :
                       (r_mode[gi] == MODE_BLINK) ? ~w_blink_on : 1'b1;
  end

  // ---------------- response FIFO ----------------
  logic       w_pop;
  logic [7:0] w_fifo_dout;
  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic       r_overflow;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_push_byte),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_fifo_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  assign o_Overflow = r_overflow;

  // ---------------- transmit handshake ----------------
  tx_state_e  r_tstate;
  tx_state_e  w_tstate_next;
  logic       r_tx_dv;
  logic [7:0] r_tx_byte;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_tstate  <= T_IDLE;
      r_tx_dv   <= 1'b0;
      r_tx_byte <= 8'h00;
    end else begin
      r_tstate <= w_tstate_next;
      r_tx_dv  <= w_pop;
      if (w_pop) r_tx_byte <= w_fifo_dout;
    end
  end

  always_comb begin
    w_tstate_next = r_tstate;
    case (r_tstate)
      T_IDLE:  if (w_pop) w_tstate_next = T_WAIT;
      T_WAIT:  if (i_TX_Done) w_tstate_next = T_IDLE;
      default: w_tstate_next = T_IDLE;
    endcase
  end

  always_comb begin
    w_pop = 1'b0;
    if (r_tstate == T_IDLE && !w_fifo_empty && !i_TX_Active) w_pop = 1'b1;
  end

  assign o_TX_DV   = r_tx_dv;
  assign o_TX_Byte = r_tx_byte;

endmodule

// File: tb/tb_uart_led_cmd.sv
// Directed bench for uart_led_cmd: a simple transmitter model answers each
// o_TX_DV with a fixed-length busy frame followed by a one-cycle Done.
`timescale 1ns/1ps
module tb_uart_led_cmd;

  localparam int FRAME = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active;
  logic       tx_done;
  logic [2:0] led;
  logic       tick;
  logic       ovf;
  logic       hold;
  logic       busy;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int proto_err = 0;
  logic [7:0] tx_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign tx_active = busy | hold;

  uart_led_cmd #(
    .NUM_CH        (3),
    .ACC_WIDTH     (32),
    .ACC_INC       (32'h4000_0000),
    .FIFO_DEPTH    (4),
    .TIMEOUT_TICKS (2)
  ) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_RX_DV     (rx_dv),
    .i_RX_Byte   (rx_byte),
    .o_TX_DV     (tx_dv),
    .o_TX_Byte   (tx_byte),
    .i_TX_Active (tx_active),
    .i_TX_Done   (tx_done),
    .o_LED       (led),
    .o_Tick      (tick),
    .o_Overflow  (ovf)
  );

  // Transmitter model: a DV while busy is a handshake violation.
  initial begin
    int left;
    left    = 0;
    busy    = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (tx_dv) begin
        if (tx_active) proto_err++;
        tx_q.push_back(tx_byte);
        busy = 1'b1;
        left = FRAME;
      end else if (busy) begin
        left--;
        if (left == 0) begin
          busy    = 1'b0;
          tx_done = 1'b1;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, act);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] exp);
    int t;
    t = 0;
    while (tx_q.size() == 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check_eq({tag, "_seen"}, 32'(tx_q.size() != 0), 32'd1);
    if (tx_q.size() != 0) check_eq(tag, 32'(tx_q.pop_front()), 32'(exp));
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 400) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    int cnt2;
    int bad;
    rst     = 1'b1;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    hold    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_led", 32'(led), 32'h7);
    check_eq("rst_txdv", 32'(tx_dv), 32'h0);
    check_eq("rst_txbyte", 32'(tx_byte), 32'h0);
    check_eq("rst_ovf", 32'(ovf), 32'h0);
    check_eq("rst_tick", 32'(tick), 32'h0);
    rst = 1'b0;

    // Long idle: no transmissions, LEDs dark
    cnt = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx_dv) cnt++;
    end
    check_eq("idle_txdv_cnt", 32'(cnt), 32'd0);
    check_eq("idle_led", 32'(led), 32'h7);
    check_eq("idle_ovf", 32'(ovf), 32'h0);

    // 'B','1': LED1 on next cycle, 'K' DV exactly two cycles after second DV
    send_byte(8'h42);
    send_byte(8'h31);
    check_eq("b1_led", 32'(led), 32'h5);
    check_eq("b1_txdv_n1", 32'(tx_dv), 32'h0);
    @(negedge clk);
    check_eq("b1_txdv_n2", 32'(tx_dv), 32'h1);
    check_eq("b1_txbyte", 32'(tx_byte), 32'h4B);
    repeat (3) @(negedge clk);
    check_eq("b1_byte_held", 32'(tx_byte), 32'h4B);
    expect_tx("b1_ack", 8'h4B);
    wait_idle();

    // 'A','2': 25% blink aligned with the accumulator wrap tick
    send_byte(8'h41);
    send_byte(8'h32);
    cnt  = 0;
    cnt2 = 0;
    bad  = 0;
    repeat (16) begin
      @(negedge clk);
      if (!led[0]) cnt++;
      if (tick) cnt2++;
      if ((!led[0]) != tick) bad++;
    end
    check_eq("blink_low_cnt", 32'(cnt), 32'd4);
    check_eq("tick_cnt", 32'(cnt2), 32'd4);
    check_eq("blink_vs_tick", 32'(bad), 32'd0);
    check_eq("blink_led1_on", 32'(led[1]), 32'h0);
    expect_tx("a2_ack", 8'h4B);
    wait_idle();

    // Invalid channel, then invalid mode: two NAKs, modes unchanged
    send_byte(8'h5A);
    send_byte(8'h43);
    send_byte(8'h37);
    expect_tx("nak_z", 8'h3F);
    expect_tx("nak_c7", 8'h3F);
    check_eq("nak_led21", 32'({led[2], led[1]}), 32'h2);
    wait_idle();

    // Timeout after a lone channel byte, then parser accepts a new command
    send_byte(8'h41);
    expect_tx("timeout_nak", 8'h3F);
    wait_idle();
    send_byte(8'h41);
    send_byte(8'h31);
    expect_tx("a1_ack", 8'h4B);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (!led[0]) cnt++;
    end
    check_eq("a1_led0_steady_on", 32'(cnt), 32'd8);
    wait_idle();

    // Overflow: transmitter held busy, six NAK-producing bytes plus a CR
    hold = 1'b1;
    repeat (4) send_byte(8'h78);
    check_eq("ovf_after4", 32'(ovf), 32'h0);
    send_byte(8'h0D);
    check_eq("ovf_after_cr", 32'(ovf), 32'h0);
    send_byte(8'h78);
    check_eq("ovf_after5", 32'(ovf), 32'h1);
    send_byte(8'h78);
    check_eq("ovf_held_q", 32'(tx_q.size()), 32'd0);
    hold = 1'b0;
    for (int i = 0; i < 4; i++) expect_tx("drain_nak", 8'h3F);
    repeat (60) @(negedge clk);
    check_eq("drain_exactly4", 32'(tx_q.size()), 32'd0);
    check_eq("ovf_sticky", 32'(ovf), 32'h1);

    // Reset mid-stream: FIFO cleared, late Done ignored
    hold = 1'b1;
    repeat (3) send_byte(8'h78);
    hold = 1'b0;
    expect_tx("pre_rst_nak", 8'h3F);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("mid_rst_txbyte", 32'(tx_byte), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ovf", 32'(ovf), 32'h0);
    check_eq("post_rst_led", 32'(led), 32'h7);
    repeat (60) @(negedge clk);
    check_eq("post_rst_no_tx", 32'(tx_q.size()), 32'd0);
    send_byte(8'h43);
    send_byte(8'h31);
    expect_tx("post_rst_ack", 8'h4B);
    check_eq("post_rst_c1_led", 32'(led), 32'h3);
    wait_idle();
    check_eq("handshake_violations", 32'(proto_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
